// File: rtl/uart_rx_monitor_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_monitor_pkg
//   Shared types and helpers for the simulation-side UART receive monitor.
//   - rx_state_e   : receiver FSM state encoding
//   - clks_per_bit : clock cycles per serial bit (integer division)
//   - half_bit     : clock cycles from start-bit edge to mid-bit sample point
//   Optional feature macro: UART_RX_MON_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_rx_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_MON_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
        return freq / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned freq,
                                             input int unsigned baud);
        return clks_per_bit(freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_monitor_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_monitor_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is presented on
//   data_o whenever the FIFO is non-empty (zero otherwise). A push into a full
//   FIFO is accepted only when a pop happens on the same edge; a pop from an
//   empty FIFO is ignored.
//   Ports:
//     clk_i, rst_i  : clock, synchronous active-high reset
//     push_i/data_i : write request and data
//     pop_i         : remove head entry
//     data_o        : head entry (FWFT)
//     full_o/empty_o: occupancy flags
//     count_o       : current occupancy
// -----------------------------------------------------------------------------
module uart_rx_monitor_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [Width-1:0]               data_i,
    input  logic                           pop_i,
    output logic [Width-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic do_push;
    logic do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_monitor.sv
// -----------------------------------------------------------------------------
// uart_rx_monitor
//   Simulation-side UART receiver for the demo system's TX line. Decodes 8N1
//   frames (8E1 with UART_RX_MON_PARITY_EN defined), buffers bytes in a FWFT
//   FIFO and presents them on a valid/ready byte interface.
//   Optional feature macro: UART_RX_MON_PARITY_EN.
//   Ports:
//     clk_i          : system clock
//     rst_i          : synchronous active-high reset
//     rx_i           : serial input, idle high
//     byte_o         : FIFO head byte, zero when empty
//     byte_valid_o   : FIFO non-empty
//     byte_ready_i   : pop head when byte_valid_o is high
//     count_o        : FIFO occupancy
//     frame_err_o    : one-cycle pulse on a low stop bit
//     overflow_o     : sticky, a received byte was dropped
//     parity_err_o   : one-cycle pulse on even-parity mismatch (macro only)
// -----------------------------------------------------------------------------
module uart_rx_monitor
    import uart_rx_monitor_pkg::*;
#(
    parameter int unsigned ClockFrequency = 50_000_000,
    parameter int unsigned BaudRate       = 115_200,
    parameter int unsigned FifoDepth      = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               rx_i,
    output logic [7:0]                         byte_o,
    output logic                               byte_valid_o,
    input  logic                               byte_ready_i,
    output logic [$clog2(FifoDepth+1)-1:0]     count_o,
    output logic                               frame_err_o,
    output logic                               overflow_o
`ifdef UART_RX_MON_PARITY_EN
    ,
    output logic                               parity_err_o
`endif
);

    localparam int unsigned ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
    localparam int unsigned HalfBit    = half_bit(ClockFrequency, BaudRate);
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);

    // Two-flop synchronizer, reset to the idle line level.
    logic rx_meta_q;
    logic rx_sync_q;

    rx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shreg_q;
    logic            frame_err_q;
    logic            overflow_q;
`ifdef UART_RX_MON_PARITY_EN
    logic            parity_bad_q;
    logic            parity_err_q;
`endif

    logic tick;
    logic push;
    logic fifo_full;
    logic fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick = (cnt_q == '0);

    // The byte is written on the stop-sample edge itself so it is visible
    // in the FIFO the following cycle.
    always_comb begin
        push = (state_q == STOP) && tick && rx_sync_q;
`ifdef UART_RX_MON_PARITY_EN
        if (parity_bad_q) begin
            push = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_MON_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef UART_RX_MON_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= START;
                        cnt_q   <= CntHalf;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_sync_q) begin
                            state_q   <= DATA;
                            cnt_q     <= CntFull;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg_q   <= {rx_sync_q, shreg_q[7:1]};
                        cnt_q     <= CntFull;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_MON_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
`ifdef UART_RX_MON_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        // Even parity: the parity bit equals the XOR of the data.
                        parity_bad_q <= (rx_sync_q != ^shreg_q);
                        cnt_q        <= CntFull;
                        state_q      <= STOP;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
`ifdef UART_RX_MON_PARITY_EN
                        parity_err_q <= parity_bad_q;
`endif
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                BREAK: begin
                    if (rx_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Any pop with a full FIFO is effective, so only a push with no pop drops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !byte_ready_i) begin
            overflow_q <= 1'b1;
        end
    end

    uart_rx_monitor_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (shreg_q),
        .pop_i   (byte_ready_i),
        .data_o  (byte_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign byte_valid_o = !fifo_empty;
    assign frame_err_o  = frame_err_q;
    assign overflow_o   = overflow_q;
`ifdef UART_RX_MON_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
module tb_uart_rx_monitor;

    localparam int unsigned CF  = 80;
    localparam int unsigned BR  = 10;
    localparam int unsigned CPB = 8;
`ifdef UART_RX_MON_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic       byte_ready_i;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic [3:0] count_o;
    logic       frame_err_o;
    logic       overflow_o;
`ifdef UART_RX_MON_PARITY_EN
    logic       parity_err_o;
`endif

    always #5 clk = ~clk;

    uart_rx_monitor #(
        .ClockFrequency (CF),
        .BaudRate       (BR),
        .FifoDepth      (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .count_o      (count_o),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o)
`ifdef UART_RX_MON_PARITY_EN
        ,
        .parity_err_o (parity_err_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Values captured around the stop-bit sample edge by send_frame.
    logic       pre_v;
    logic       post_v;
    logic [7:0] post_byte;
    logic [3:0] post_cnt;
    logic       post_ferr;
    logic       after_ferr;
    logic       post_perr;
    logic       after_perr;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned low_hold;
        logic        exp_valid;
        logic [7:0]  exp_byte;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame starting right after a clock edge; each bit lasts CPB
    // cycles. The DUT samples the stop bit on the 7th edge of the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip, input logic pop_at_stop);
        logic [NB-1:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_MON_PARITY_EN
        bits[9]   = (^d) ^ par_flip;
`else
        if (par_flip) bits[0] = 1'b0;
`endif
        bits[NB-1] = stop;
        post_perr  = 1'b0;
        after_perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            rx_i = bits[b];
            for (int c = 0; c < int'(CPB); c++) begin
                if (b == NB - 1 && c == 6 && pop_at_stop) byte_ready_i = 1'b1;
                tick();
                if (b == NB - 1) begin
                    if (c == 5) pre_v = byte_valid_o;
                    if (c == 6) begin
                        post_v    = byte_valid_o;
                        post_byte = byte_o;
                        post_cnt  = count_o;
                        post_ferr = frame_err_o;
`ifdef UART_RX_MON_PARITY_EN
                        post_perr = parity_err_o;
`endif
                        if (pop_at_stop) byte_ready_i = 1'b0;
                    end
                    if (c == 7) begin
                        after_ferr = frame_err_o;
`ifdef UART_RX_MON_PARITY_EN
                        after_perr = parity_err_o;
`endif
                    end
                end
            end
        end
    endtask

    task automatic pop_check(input logic [7:0] exp);
        check("pop_valid", byte_valid_o, 1'b1);
        check("pop_byte", byte_o, exp);
        byte_ready_i = 1'b1;
        tick();
        byte_ready_i = 1'b0;
    endtask

    initial begin
        logic seen_ferr;
        logic seen_valid;

        rst_i        = 1'b1;
        rx_i         = 1'b1;
        byte_ready_i = 1'b0;
        repeat (3) tick();
        check("rst_byte", byte_o, 8'h00);
        check("rst_valid", byte_valid_o, 1'b0);
        check("rst_count", count_o, 4'd0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
`ifdef UART_RX_MON_PARITY_EN
        check("rst_perr", parity_err_o, 1'b0);
`endif
        rst_i = 1'b0;
        repeat (4) tick();

        // Single frames with a consumer that is always ready.
        vecs[0] = '{8'h55, 1'b1, 0,  1'b1, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 20, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 0,  1'b1, 8'h3C, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 0,  1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 0,  1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 0,  1'b1, 8'h81, 1'b0};
        byte_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
            check("vec_pre_valid", pre_v, 1'b0);
            check("vec_valid", post_v, vecs[i].exp_valid);
            check("vec_byte", post_byte, vecs[i].exp_byte);
            check("vec_count", post_cnt, {3'd0, vecs[i].exp_valid});
            check("vec_ferr", post_ferr, vecs[i].exp_ferr);
            check("vec_ferr_1cyc", after_ferr, 1'b0);
            check("vec_perr", post_perr, 1'b0);
            repeat (vecs[i].low_hold) tick();
            rx_i = 1'b1;
            repeat (4) tick();
            check("vec_count_after", count_o, 4'd0);
            check("vec_valid_after", byte_valid_o, 1'b0);
        end

        // Short low glitch: rejected at the start-bit sample, nothing reported.
        rx_i = 1'b0;
        repeat (3) tick();
        rx_i = 1'b1;
        seen_ferr  = 1'b0;
        seen_valid = 1'b0;
        repeat (16) begin
            tick();
            seen_ferr  = seen_ferr | frame_err_o;
            seen_valid = seen_valid | byte_valid_o;
        end
        check("glitch_ferr", seen_ferr, 1'b0);
        check("glitch_valid", seen_valid, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("glitch_next_valid", post_v, 1'b1);
        check("glitch_next_byte", post_byte, 8'h3C);
        repeat (4) tick();

        // Nine back-to-back frames into an 8-entry FIFO with no consumer.
        byte_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        check("full_count", count_o, 4'd8);
        check("full_ovf", overflow_o, 1'b0);
        send_frame(8'h09, 1'b1, 1'b0, 1'b0);
        check("ovf_count", count_o, 4'd8);
        check("ovf_flag", overflow_o, 1'b1);
        for (int i = 1; i <= 8; i++) pop_check(8'(i));
        check("drained_count", count_o, 4'd0);
        check("drained_byte", byte_o, 8'h00);
        check("ovf_sticky", overflow_o, 1'b1);
        byte_ready_i = 1'b1;
        tick();
        byte_ready_i = 1'b0;
        check("pop_empty_count", count_o, 4'd0);

        rst_i = 1'b1;
        tick();
        check("rst2_ovf", overflow_o, 1'b0);
        rst_i = 1'b0;
        repeat (2) tick();

        // Full FIFO with a pop coinciding with the push of 0x10.
        for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
        check("fill_count", count_o, 4'd8);
        send_frame(8'h10, 1'b1, 1'b0, 1'b1);
        check("coinc_count", post_cnt, 4'd8);
        check("coinc_ovf", overflow_o, 1'b0);
        for (int i = 1; i < 8; i++) pop_check(8'h20 + 8'(i));
        pop_check(8'h10);
        check("coinc_drained", count_o, 4'd0);

        // Reset in the middle of the data bits of 0xF0.
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", count_o, 4'd1);
        rx_i = 1'b0;
        repeat (8 * 4) tick();
        rst_i = 1'b1;
        rx_i  = 1'b1;
        tick();
        check("midrst_byte", byte_o, 8'h00);
        check("midrst_valid", byte_valid_o, 1'b0);
        check("midrst_count", count_o, 4'd0);
        check("midrst_ferr", frame_err_o, 1'b0);
        check("midrst_ovf", overflow_o, 1'b0);
        rst_i = 1'b0;
        repeat (20) tick();
        check("midrst_quiet", count_o, 4'd0);
        byte_ready_i = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check("after_rst_valid", post_v, 1'b1);
        check("after_rst_byte", post_byte, 8'h5A);
        repeat (4) tick();

`ifdef UART_RX_MON_PARITY_EN
        // 0x07 has odd weight, so a parity bit of 0 is wrong for even parity.
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("par_perr", post_perr, 1'b1);
        check("par_perr_1cyc", after_perr, 1'b0);
        check("par_valid", post_v, 1'b0);
        check("par_count", post_cnt, 4'd0);
        repeat (4) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Simulation-side UART receiver that sits on the demo system's UART transmit line in the Verilator top level and consumes the serial stream the demo system produces. It decodes 8N1 frames at a fixed baud rate, buffers received bytes in a small FIFO, and presents them on a valid/ready byte interface for a console, checker or end-of-test detector. It also reports framing errors and FIFO overflow so benches can fail on corrupted output.

## Interface
- ClockFrequency, 50_000_000, clock frequency in Hz
- BaudRate, 115_200, line rate in bits/s; ClksPerBit = ClockFrequency / BaudRate (integer division, must be ≥ 4)
- FifoDepth, 8, byte FIFO entries; power of two, ≥ 2
- clk_i  input  1  system clock; only clock in the block
- rst_i  input  1  synchronous, active-high reset
- rx_i  input  1  serial line from the demo system's UART TX; idle high
- byte_o  output  8  FIFO head byte; 8'h00 when FIFO empty
- byte_valid_o  output  1  FIFO non-empty
- byte_ready_i  input  1  consumer pops the head when byte_valid_o && byte_ready_i
- count_o  output  $clog2(FifoDepth+1)  current FIFO occupancy
- frame_err_o  output  1  one-cycle pulse on bad stop bit
- overflow_o  output  1  sticky; set when a byte is dropped, cleared only by rst_i
- parity_err_o  output  1  one-cycle pulse on parity mismatch (present only with UART_RX_MON_PARITY_EN)

## Operation
- rx_i passes through a 2-flop synchronizer reset to 1; the FSM sees only the synchronized bit.
- FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK. Bit counter counts down; "tick" = counter reaches 0.
- IDLE: synced rx == 0 -> START, counter = ClksPerBit/2 - 1.
- START: on tick, rx == 0 -> DATA, counter = ClksPerBit - 1, bit index 0; rx == 1 -> IDLE (glitch rejected, nothing reported).
- DATA: on each tick shift rx in LSB-first, reload counter; after bit 7 -> PARITY (macro) or STOP.
- STOP: on tick, rx == 1 -> push byte, -> IDLE; rx == 0 -> frame_err_o pulse, byte discarded, -> BREAK.
- BREAK: wait for synced rx == 1, then -> IDLE.
- FIFO push when full: accepted only if a pop occurs the same cycle; otherwise byte dropped, overflow_o set. Pop when empty ignored.
- Simultaneous push and pop: count_o unchanged, order preserved.
- rst_i mid-frame: FSM -> IDLE, FIFO emptied, partial byte discarded, all outputs to reset values.

## Timing
- Reset values: byte_o 0, byte_valid_o 0, count_o 0, frame_err_o 0, overflow_o 0, parity_err_o 0.
- Bit samples taken ClksPerBit/2 after the synchronized falling edge, then every ClksPerBit cycles.
- Latency: byte_valid_o/byte_o/count_o update the cycle after the stop-bit sample cycle; frame_err_o/parity_err_o asserted that same following cycle for exactly 1 cycle.
- FIFO is first-word-fall-through; pop takes effect at the clock edge, next head visible the following cycle.
- Return to IDLE at mid-stop-bit allows back-to-back frames with no idle gap.
- Total synchronizer delay: 2 cycles from rx_i to FSM.

## Configuration
- UART_RX_MON_PARITY_EN defined: frame is 8E1; PARITY state samples one extra bit; mismatch with even parity of data -> parity_err_o pulse, byte discarded, FSM continues to STOP normally.
- Undefined: 8N1 only; no PARITY state; parity_err_o port absent.

## Structure
- Package uart_rx_monitor_pkg: state enum typedef (rx_state_e), function computing ClksPerBit and half-bit value.
- One sub-module: uart_rx_monitor_fifo (parameterised synchronous FWFT FIFO, push/pop/full/empty/count).

## Test plan
Bench params: ClockFrequency 80, BaudRate 10 (ClksPerBit 8).
- Frame 0x55, ready=1 -> byte_o 0x55, byte_valid_o high 1 cycle after stop sample, count_o 1 then 0 after pop.
- rx_i low 3 cycles then high -> no byte, no frame_err_o, FSM back to IDLE; following 0x3C received correctly.
- Frame 0xA3 with stop bit 0, line held low 20 cycles -> frame_err_o one-cycle pulse, count_o stays 0; next frame 0x3C after line high received.
- 9 back-to-back frames 0x01..0x09, ready=0 -> count_o 8, overflow_o 1, popping yields 0x01..0x08 in order.
- FIFO full, pop coincident with push of 0x10 -> count_o stays 8, 0x10 is last entry, overflow_o unchanged.
- rst_i pulsed during DATA of 0xF0 -> all outputs reset values; next frame 0x5A received; with UART_RX_MON_PARITY_EN, 0x07 sent with parity bit 0 -> parity_err_o pulse, no push.
